fifo_wr_packer: RTL and testbench

Write-side producer for the dual-clock FIFO. Accepts a byte stream on a valid/ready handshake and packs LANES bytes into one FIFO word tagged with a byte count and a last flag. It drives the FIFO write port in the wr_clk domain, honours full, optionally throttles on prog_full, and checks every write acknowledgement. Sits between the MPEG2 output byte path and the clock-crossing FIFO toward the consumer domain.

---
 rtl/wr_packer_pkg.sv | 16 +
 rtl/wr_packer_hold.sv | 32 +++
 rtl/fifo_wr_packer.sv | 78 +++++++
 tb/tb_fifo_wr_packer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wr_packer_pkg.sv
// wr_packer_pkg: shared word layout and error bit indices for the FIFO packer/unpacker pair
package wr_packer_pkg;
  localparam int LANES = 4;
  localparam int CNT_W = $clog2(LANES);
  localparam int FW = 8 * LANES + CNT_W + 1;
  localparam int DATA_LSB = 0;
  localparam int CNT_LSB = 8 * LANES;
  localparam int LAST_BIT = FW - 1;
  localparam int ERR_OVF = 0;
  localparam int ERR_ACK = 1;
  typedef logic [FW-1:0] word_t;
  function automatic word_t pack_word(input logic last, input logic [CNT_W-1:0] cnt,
                                      input logic [8*LANES-1:0] data);
    return {last, cnt, data};
  endfunction
endpackage

// File: rtl/wr_packer_hold.sv
// wr_packer_hold: one-word hold register driving the FIFO write port and tracking the pending ack
module wr_packer_hold
  import wr_packer_pkg::*;
(
  input  logic  wr_clk,
  input  logic  rst,
  input  logic  load_i,
  input  word_t word_i,
  input  logic  fifo_full,
  output logic  hold_v_o,
  output word_t fifo_din,
  output logic  fifo_wr_en,
  output logic  ack_pend_o
);
  word_t hold_q;
  logic  hold_v_q, ack_pend_q;
  assign fifo_wr_en = hold_v_q & ~fifo_full;
  assign fifo_din = hold_q;
  assign hold_v_o = hold_v_q;
  assign ack_pend_o = ack_pend_q;
  // hold keeps its word while full; a new word may replace one draining this cycle
  always_ff @(posedge wr_clk or negedge rst)
    if (!rst) begin
      hold_q <= '0;
      hold_v_q <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      hold_v_q <= load_i | (hold_v_q & fifo_full);
      if (load_i) hold_q <= word_i;
      ack_pend_q <= fifo_wr_en;
    end
endmodule

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs a byte stream into tagged FIFO words and checks write acknowledgements
module fifo_wr_packer
  import wr_packer_pkg::*;
#(
  parameter bit THROTTLE = 1'b1
) (
  input  logic        rst,
  input  logic        wr_clk,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        flush,
  output word_t       fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  input  logic        fifo_wr_ack,
  input  logic        fifo_overflow,
  input  logic        fifo_prog_full,
  output logic [31:0] words_written,
  output logic [1:0]  err,
  output logic        busy
);
  logic [8*LANES-1:0] acc_q, acc_d, data_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               flush_pend_q, flush_pend_d, en_q;
  logic [31:0]        words_q;
  logic [1:0]         err_q, err_d;
  logic               hold_v, ack_pend, can_load, accept, fl, load;
  word_t              word;
  // accumulate bytes into lanes and decide when the word closes into hold
  always_comb begin
    can_load = en_q & (~hold_v | ~fifo_full);
    in_ready = can_load & ~(THROTTLE & fifo_prog_full);
    accept = in_valid & in_ready;
    fl = flush_pend_q | flush;
    data_d = accept ? acc_q | ({{(8*LANES-8){1'b0}}, in_data} << {idx_q, 3'b000}) : acc_q;
    load = accept ? (idx_q == CNT_W'(LANES - 1)) | in_last | fl : fl & (idx_q != '0) & can_load;
    word = pack_word(accept & in_last, accept ? idx_q : idx_q - CNT_W'(1), data_d);
    idx_d = load ? '0 : idx_q + CNT_W'(accept);
    acc_d = load ? '0 : data_d;
    flush_pend_d = fl & ~load & (accept | (idx_q != '0));
    err_d = err_q;
    err_d[ERR_ACK] = err_q[ERR_ACK] | (ack_pend ^ fifo_wr_ack);
    err_d[ERR_OVF] = err_q[ERR_OVF] | fifo_overflow;
  end
  // accumulator, flush tracking, ack counter and sticky errors
  always_ff @(posedge wr_clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      idx_q <= '0;
      flush_pend_q <= 1'b0;
      en_q <= 1'b0;
      words_q <= '0;
      err_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      flush_pend_q <= flush_pend_d;
      en_q <= 1'b1;
      words_q <= words_q + 32'(fifo_wr_ack);
      err_q <= err_d;
    end
  wr_packer_hold u_hold (
    .wr_clk     (wr_clk),
    .rst        (rst),
    .load_i     (load),
    .word_i     (word),
    .fifo_full  (fifo_full),
    .hold_v_o   (hold_v),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .ack_pend_o (ack_pend)
  );
  assign words_written = words_q;
  assign err = err_q;
  assign busy = (idx_q != '0) | hold_v | ack_pend | flush_pend_q;
endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: directed scoreboard bench for the FIFO write-side packer
module tb_fifo_wr_packer;
  import wr_packer_pkg::*;
  logic        wr_clk = 0, rst = 0, in_valid = 0, in_last = 0, flush = 0;
  logic        fifo_full = 0, fifo_wr_ack = 0, fifo_overflow = 0, fifo_prog_full = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready, fifo_wr_en, busy;
  word_t       fifo_din;
  logic [31:0] words_written;
  logic [1:0]  err;
  int          checks = 0, failures = 0, cyc = 0;
  bit          sup_ack = 0;
  word_t       exp_q[$];
  int          wr_cyc[$];

  fifo_wr_packer #(.THROTTLE(1'b1)) dut (
    .rst(rst), .wr_clk(wr_clk), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .flush(flush), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .fifo_prog_full(fifo_prog_full), .words_written(words_written), .err(err), .busy(busy)
  );

  always #5 wr_clk = ~wr_clk;

  always @(posedge wr_clk) begin
    cyc <= cyc + 1;
    fifo_wr_ack <= fifo_wr_en & ~sup_ack;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge wr_clk) begin
    word_t e;
    if (rst && fifo_wr_en) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      wr_cyc.push_back(cyc);
      chk("din", fifo_din, e);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wr_clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    bit ok;
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    do begin
      @(negedge wr_clk);
      ok = in_ready;
      @(posedge wr_clk);
      #1;
      n++;
    end while (!ok && n < 50);
    chk("accept", ok, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      tick(1);
      n++;
    end
    chk("idle", busy, 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_words", words_written, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b[8];
    int c0, k, n, wr_seen;
    bit ok;
    #2;
    check_reset_outputs();
    @(negedge wr_clk);
    rst = 1;
    #1 chk("ready_before_edge", in_ready, 0);
    tick(1);
    chk("ready_after_rst", in_ready, 1);

    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h04030201));
    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h08070605));
    wr_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) put(8'(i + 1), 1'b0);
    wait_idle();
    chk("stream_wr_count", wr_cyc.size(), 2);
    chk("stream_lat0", wr_cyc[0] - c0, 4);
    chk("stream_lat1", wr_cyc[1] - c0, 8);
    chk("stream_words", words_written, 2);
    chk("stream_sb_empty", exp_q.size(), 0);

    exp_q.push_back(pack_word(1'b1, 2'd1, 32'h0000BBAA));
    put(8'hAA, 1'b0);
    put(8'hBB, 1'b1);
    wait_idle();
    chk("last_words", words_written, 3);

    exp_q.push_back(pack_word(1'b0, 2'd2, 32'h00332211));
    put(8'h11, 1'b0);
    put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    tick(2);
    chk("partial_busy", busy, 1);
    chk("partial_no_wr", words_written, 3);
    flush = 1;
    tick(1);
    flush = 0;
    chk("flush_busy1", busy, 1);
    tick(1);
    chk("flush_busy2", busy, 1);
    tick(1);
    chk("flush_busy_drop", busy, 0);
    chk("flush_words", words_written, 4);
    flush = 1;
    tick(1);
    flush = 0;
    chk("flush_empty_busy", busy, 0);
    tick(3);
    chk("flush_empty_words", words_written, 4);

    for (int i = 0; i < 8; i++) b[i] = 8'(8'h41 + i);
    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h44434241));
    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h48474645));
    fifo_full = 1;
    k = 0; wr_seen = 0;
    in_valid = 1; in_data = b[0];
    repeat (10) begin
      @(negedge wr_clk);
      ok = in_ready;
      wr_seen += int'(fifo_wr_en);
      @(posedge wr_clk);
      #1;
      if (ok) begin
        k++;
        if (k < 8) in_data = b[k]; else in_valid = 0;
      end
    end
    chk("full_absorbed", k, 4);
    chk("full_ready", in_ready, 0);
    chk("full_no_wr", wr_seen, 0);
    fifo_full = 0;
    n = 0;
    while (k < 8 && n < 40) begin
      @(negedge wr_clk);
      ok = in_ready;
      @(posedge wr_clk);
      #1;
      n++;
      if (ok) begin
        k++;
        if (k < 8) in_data = b[k]; else in_valid = 0;
      end
    end
    in_valid = 0;
    chk("full_all_taken", k, 8);
    wait_idle();
    chk("full_words", words_written, 6);
    chk("full_err", err, 0);
    chk("full_sb_empty", exp_q.size(), 0);

    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h54535251));
    fifo_full = 1;
    for (int i = 0; i < 4; i++) put(8'(8'h51 + i), 1'b0);
    tick(1);
    chk("thr_busy", busy, 1);
    chk("thr_hold_blocks", in_ready, 0);
    fifo_prog_full = 1;
    fifo_full = 0;
    #1;
    chk("thr_ready", in_ready, 0);
    chk("thr_drain", fifo_wr_en, 1);
    tick(4);
    chk("thr_words", words_written, 7);
    chk("thr_ready_held", in_ready, 0);
    fifo_prog_full = 0;
    #1 chk("thr_release", in_ready, 1);

    exp_q.push_back(pack_word(1'b0, 2'd3, 32'h64636261));
    sup_ack = 1;
    for (int i = 0; i < 4; i++) put(8'(8'h61 + i), 1'b0);
    tick(3);
    sup_ack = 0;
    tick(2);
    chk("ack_err", err, 2'b10);
    chk("ack_words", words_written, 7);
    tick(3);
    chk("ack_sticky", err, 2'b10);
    fifo_overflow = 1;
    tick(1);
    fifo_overflow = 0;
    chk("ovf_err", err, 2'b11);

    put(8'h71, 1'b0);
    put(8'h72, 1'b0);
    chk("mid_busy", busy, 1);
    rst = 0;
    #1;
    check_reset_outputs();
    tick(2);
    rst = 1;
    tick(8);
    chk("post_rst_words", words_written, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err, 0);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
